// File: rtl/zilla_dm_responder.sv
// Data-memory responder for the core's load/store port: byte-strobed writes, fixed-latency
// pipelined reads, a pulse for each rejected request and saturating access counters.
module zilla_dm_responder #(
    parameter int unsigned        D_WIDTH     = 32,
    parameter int unsigned        DEPTH_WORDS = 1024,
    parameter logic [D_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned        RD_LAT      = 1
) (
    input  logic                 risc_clk,
    input  logic                 risc_rst,
    input  logic                 data_mem_write_en_o,
    input  logic [D_WIDTH-1:0]   data_mem_write_addr_o,
    input  logic [D_WIDTH-1:0]   data_mem_write_data_o,
    input  logic [D_WIDTH/8-1:0] data_mem_strobe_o,
    input  logic                 data_mem_read_en_o,
    input  logic [D_WIDTH-1:0]   data_mem_read_addr_o,
    output logic [D_WIDTH-1:0]   data_mem_read_data_i,
    output logic                 dm_rd_valid,
    output logic                 dm_err,
    output logic [15:0]          dm_rd_cnt,
    output logic [15:0]          dm_wr_cnt
);

    localparam int AW  = $clog2(DEPTH_WORDS);
    localparam int NB  = D_WIDTH / 8;
    localparam int LAT = RD_LAT;

    // ------------------------------------------------------------------
    // Address decode: word-aligned and inside the window starting at BASE_ADDR.
    // Addresses below the base wrap to a huge offset and fall out of range.
    // ------------------------------------------------------------------
    logic [D_WIDTH-1:0] wr_off;
    logic [D_WIDTH-1:0] rd_off;
    logic [AW-1:0]      wr_idx;
    logic [AW-1:0]      rd_idx;
    logic               wr_ok;
    logic               rd_ok;
    logic               wr_acc;
    logic               rd_acc;
    logic               any_rej;

    assign wr_off = data_mem_write_addr_o - BASE_ADDR;
    assign rd_off = data_mem_read_addr_o - BASE_ADDR;
    assign wr_idx = wr_off[AW+1:2];
    assign rd_idx = rd_off[AW+1:2];
    assign wr_ok  = (wr_off[1:0] == 2'b00) && (wr_off[D_WIDTH-1:AW+2] == '0);
    assign rd_ok  = (rd_off[1:0] == 2'b00) && (rd_off[D_WIDTH-1:AW+2] == '0);

    // Requests presented while reset is held are ignored, including writes to the array.
    assign wr_acc  = risc_rst & data_mem_write_en_o & wr_ok;
    assign rd_acc  = data_mem_read_en_o & rd_ok;
    assign any_rej = (data_mem_write_en_o & ~wr_ok) | (data_mem_read_en_o & ~rd_ok);

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    logic [D_WIDTH-1:0] mem [DEPTH_WORDS];

    // NOTE: the array deliberately has no reset branch; contents must survive reset and a
    // resettable array cannot map onto RAM macros.
    always_ff @(posedge risc_clk) begin
        if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (data_mem_strobe_o[b]) begin
                    mem[wr_idx][8*b +: 8] <= data_mem_write_data_o[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 0 captures the array word at the request edge, later stages
    // only shift. Each stage holds its data while no valid passes through it, so the
    // last stage keeps presenting the most recent return.
    // ------------------------------------------------------------------
    logic [LAT-1:0]     vld_pipe;
    logic [D_WIDTH-1:0] dat_pipe [LAT];

    // NOTE: non-blocking assignments make stage 0 see the array as it was before any write
    // at the same edge, which gives read-before-write on a same-word collision.
    always_ff @(posedge risc_clk or negedge risc_rst) begin
        if (!risc_rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= data_mem_read_en_o;
            if (data_mem_read_en_o) begin
                dat_pipe[0] <= rd_ok ? mem[rd_idx] : '0;
            end
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) begin
                    dat_pipe[i] <= dat_pipe[i-1];
                end
            end
        end
    end

    assign dm_rd_valid          = vld_pipe[LAT-1];
    assign data_mem_read_data_i = dat_pipe[LAT-1];

    // ------------------------------------------------------------------
    // Reject pulse and saturating counters. A rejected read and write at the same
    // edge merge into a single pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge risc_clk or negedge risc_rst) begin
        if (!risc_rst) begin
            dm_err    <= 1'b0;
            dm_rd_cnt <= '0;
            dm_wr_cnt <= '0;
        end else begin
            dm_err <= any_rej;
            if (rd_acc && (dm_rd_cnt != 16'hFFFF)) begin
                dm_rd_cnt <= dm_rd_cnt + 16'd1;
            end
            if (wr_acc && (dm_wr_cnt != 16'hFFFF)) begin
                dm_wr_cnt <= dm_wr_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/zilla_dm_responder.md
ZILLA_DM_RESPONDER -- requirements
Module: zilla_dm_responder

Interface
REQ-001 Parameter D_WIDTH, default 32, data bus width in bits; the block supports only 32.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of words in the memory array; must be a power of 2.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.
REQ-004 Parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-005 risc_clk  in  1  single clock; all logic is on its rising edge.
REQ-006 risc_rst  in  1  asynchronous, active-low reset.
REQ-007 data_mem_write_en_o  in  1  write request qualifier from the core.
REQ-008 data_mem_write_addr_o  in  D_WIDTH  write byte address.
REQ-009 data_mem_write_data_o  in  D_WIDTH  write data.
REQ-010 data_mem_strobe_o  in  D_WIDTH/8  write byte enables; bit n enables byte lane n.
REQ-011 data_mem_read_en_o  in  1  read request qualifier.
REQ-012 data_mem_read_addr_o  in  D_WIDTH  read byte address.
REQ-013 data_mem_read_data_i  out  D_WIDTH  read data returned to the core.
REQ-014 dm_rd_valid  out  1  read data is valid this cycle.
REQ-015 dm_err  out  1  one-cycle pulse flagging a rejected access.
REQ-016 dm_rd_cnt, dm_wr_cnt  out  16 each  saturating counts of accepted reads and accepted writes.

Function
REQ-017 The word index SHALL be (addr - BASE_ADDR) >> 2; an access is accepted only if addr[1:0] == 0 and the index is below DEPTH_WORDS.
REQ-018 An accepted write SHALL update only the byte lanes whose strobe bit is set, at the rising edge where data_mem_write_en_o = 1.
REQ-019 A write with all strobe bits at 0 SHALL be accepted, SHALL leave memory unchanged, and SHALL increment dm_wr_cnt.
REQ-020 A read sampled at edge N SHALL drive data_mem_read_data_i and dm_rd_valid = 1 during the cycle that follows edge N+RD_LAT-1; results come out through an RD_LAT-deep valid/data pipeline.
REQ-021 Back-to-back reads SHALL be accepted every cycle with no bubbles, and results SHALL return in issue order.
REQ-022 When a read and a write arrive at the same edge to the same word, the read SHALL return the pre-write contents.
REQ-023 A write at edge N SHALL be visible to any read sampled at edge N+1 or later.
REQ-024 A rejected read (misaligned or out of range) SHALL still produce dm_rd_valid at normal latency, with data 32'h0000_0000.
REQ-025 A rejected write SHALL leave memory unchanged.
REQ-026 A rejected access of either kind SHALL assert dm_err for exactly 1 cycle, in the cycle after the request edge; a rejected read and a rejected write at the same edge SHALL produce one pulse.
REQ-027 Rejected accesses SHALL NOT increment the counters.
REQ-028 Each counter SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-029 dm_rd_valid SHALL be 0 and data_mem_read_data_i SHALL hold its last value in any cycle that has no returning read.
REQ-030 X on a request qualifier is illegal; the block may ignore it.

Reset
REQ-031 While risc_rst = 0, the block SHALL drive dm_rd_valid = 0, dm_err = 0, data_mem_read_data_i = 0, dm_rd_cnt = 0, dm_wr_cnt = 0, and SHALL clear the pipeline.
REQ-032 Memory array contents SHALL NOT be cleared by reset.
REQ-033 Reads still in flight when reset asserts SHALL be discarded and SHALL never return.
REQ-034 The first request SHALL be sampled at the first rising edge after risc_rst deasserts.

Verification
REQ-035 Write 32'hDEAD_BEEF to 0x10 with strobe 4'hF, then write 32'h0000_0055 to 0x10 with strobe 4'h1, then read 0x10 -> 32'hDEAD_BE55 returned RD_LAT cycles after the read edge; dm_wr_cnt = 2, dm_rd_cnt = 1.
REQ-036 Same-edge read and write of 32'h1111_1111 to 0x20, which holds 32'hAAAA_AAAA -> read returns 32'hAAAA_AAAA; a read on the next cycle returns 32'h1111_1111.
REQ-037 Read of 0x13 (misaligned), then write to BASE_ADDR + DEPTH_WORDS*4 (out of range) -> each produces a 1-cycle dm_err pulse; the read returns 0 with dm_rd_valid; memory and counters are unchanged.
REQ-038 RD_LAT = 3, reads issued on 8 consecutive cycles to 0x0..0x1C -> 8 consecutive valid cycles in address order, the first at edge +2.
REQ-039 Reset asserted with 2 reads in flight -> no dm_rd_valid afterwards, counters are 0, and a read after reset returns the data written before reset.
REQ-040 Counter preloaded by 65 535 accepted writes, then 1 more write -> dm_wr_cnt stays 16'hFFFF.
